// File: rtl/cmsdk_fpga_sram_pipe.sv
// Byte-writable single-port SRAM with zero-fill after reset and a
// 1- or 2-stage read pipeline; RDATA is forced to zero when not valid.
module cmsdk_fpga_sram_pipe #(
  parameter int AW        = 16,
  parameter int DW        = 32,
  parameter int RD_LAT    = 1,
  parameter int INIT_ZERO = 1
) (
  input  logic            CLK,
  input  logic            RESETn,
  input  logic            CS,
  input  logic [AW-1:0]   ADDR,
  input  logic [DW-1:0]   WDATA,
  input  logic [DW/8-1:0] WREN,
  output logic [DW-1:0]   RDATA,
  output logic            RVALID,
  output logic            READY
);

  localparam int NB    = DW / 8;
  localparam int DEPTH = 2 ** AW;

  localparam logic [AW-1:0] LAST = '1;

  typedef enum logic {
    INIT,
    RUN
  } state_t;

  state_t        state;
  logic          ready_q;
  logic [AW-1:0] init_cnt;

  logic [DW-1:0] mem [DEPTH];

  logic          access;
  logic [DW-1:0] rd_old;
  logic [DW-1:0] wr_mask;
  logic [DW-1:0] merged;

  assign access = (state == RUN) && CS;

  // Write-first: the read word already carries this cycle's new bytes.
  always_comb begin
    wr_mask = '0;
    for (int i = 0; i < NB; i++) begin
      wr_mask[8*i +: 8] = {8{WREN[i]}};
    end
    rd_old = mem[ADDR];
    merged = (WDATA & wr_mask) | (rd_old & ~wr_mask);
  end

  // Array has no reset; the fill pass zeroes it instead.
  always_ff @(posedge CLK) begin
    if (state == INIT) begin
      mem[init_cnt] <= '0;
    end else if (access && (|WREN)) begin
      mem[ADDR] <= merged;
    end
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state    <= (INIT_ZERO != 0) ? INIT : RUN;
      ready_q  <= (INIT_ZERO == 0);
      init_cnt <= '0;
    end else begin
      unique case (state)
        INIT: begin
          if (init_cnt == LAST) begin
            state   <= RUN;
            ready_q <= 1'b1;
          end else begin
            init_cnt <= init_cnt + 1'b1;
          end
        end
        RUN: begin
          state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

  assign READY = ready_q;

  logic          v1;
  logic [DW-1:0] d1;

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      v1 <= 1'b0;
      d1 <= '0;
    end else begin
      v1 <= access;
      d1 <= access ? merged : '0;
    end
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic          v2;
      logic [DW-1:0] d2;

      always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
          v2 <= 1'b0;
          d2 <= '0;
        end else begin
          v2 <= v1;
          d2 <= d1;
        end
      end

      assign RVALID = v2;
      assign RDATA  = d2;
    end else begin : g_lat1
      assign RVALID = v1;
      assign RDATA  = d1;
    end
  endgenerate

endmodule
